// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite master definitions: response codes, FSM state
// encodings and default channel widths.
package axi_lite_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned STRB_W_DEF = DATA_W_DEF / 8;
   localparam int unsigned RESP_W_DEF = 2;
   localparam int unsigned PROT_W_DEF = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

endpackage

// File: rtl/axi_lite_master_interface_if.sv
// AXI-Lite five-channel bundle (AW, W, B, AR, R).
// master: drives addr/data/valid + bready/rready; slave: the reverse.
interface axi_lite_master_interface_if #(
   parameter int unsigned ADDR_WIDTH      = axi_lite_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH      = axi_lite_pkg::DATA_W_DEF,
   parameter int unsigned TRANS_W_STRB_W  = axi_lite_pkg::STRB_W_DEF,
   parameter int unsigned TRANS_WR_RESP_W = axi_lite_pkg::RESP_W_DEF,
   parameter int unsigned TRANS_PROT      = axi_lite_pkg::PROT_W_DEF
) ();

   logic [ADDR_WIDTH-1:0]      awaddr;
   logic [TRANS_PROT-1:0]      awprot;
   logic                       awvalid;
   logic                       awready;

   logic [DATA_WIDTH-1:0]      wdata;
   logic [TRANS_W_STRB_W-1:0]  wstrb;
   logic                       wvalid;
   logic                       wready;

   logic [TRANS_WR_RESP_W-1:0] bresp;
   logic                       bvalid;
   logic                       bready;

   logic [ADDR_WIDTH-1:0]      araddr;
   logic [TRANS_PROT-1:0]      arprot;
   logic                       arvalid;
   logic                       arready;

   logic [DATA_WIDTH-1:0]      rdata;
   logic [TRANS_WR_RESP_W-1:0] rresp;
   logic                       rvalid;
   logic                       rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_lite_master_wr_engine.sv
// AXI-Lite write engine: one local write -> AW + W, then waits on B.
// Ports: clk_i/resetn_i, i_wr_* request, o_wr_* status, axi (AW/W/B).
module axi_lite_master_wr_engine
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH      = DATA_W_DEF,
   parameter int unsigned TRANS_W_STRB_W  = STRB_W_DEF,
   parameter int unsigned TRANS_WR_RESP_W = RESP_W_DEF,
   parameter int unsigned TRANS_PROT      = PROT_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       resetn_i,
   input  logic                       i_wr_req,
   input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
   input  logic [DATA_WIDTH-1:0]      i_wr_data,
   input  logic [TRANS_W_STRB_W-1:0]  i_wr_strb,
   input  logic [TRANS_PROT-1:0]      i_wr_prot,
   output logic                       o_wr_busy,
   output logic                       o_wr_done,
   output logic [TRANS_WR_RESP_W-1:0] o_wr_resp,
   axi_lite_master_interface_if.master axi
);

   wr_state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]      awaddr_q, awaddr_d;
   logic [TRANS_PROT-1:0]      awprot_q, awprot_d;
   logic                       awvalid_q, awvalid_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic [TRANS_W_STRB_W-1:0]  wstrb_q, wstrb_d;
   logic                       wvalid_q, wvalid_d;
   logic                       bready_q, bready_d;
   logic [TRANS_WR_RESP_W-1:0] resp_q, resp_d;
   logic                       done_q, done_d;

   // A channel counts as finished once its VALID is already low or
   // handshakes this cycle, so AW and W may complete in either order.
   logic aw_fin, w_fin;
   assign aw_fin = !awvalid_q || axi.awready;
   assign w_fin  = !wvalid_q  || axi.wready;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q   <= W_IDLE;
         awaddr_q  <= '0;
         awprot_q  <= '0;
         awvalid_q <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         resp_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         awprot_q  <= awprot_d;
         awvalid_q <= awvalid_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         resp_q    <= resp_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         W_IDLE: if (i_wr_req) state_d = W_SEND;
         W_SEND: if (aw_fin && w_fin) state_d = W_RESP;
         W_RESP: if (axi.bvalid && bready_q) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awaddr_d  = awaddr_q;
      awprot_d  = awprot_q;
      awvalid_d = awvalid_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      resp_d    = resp_q;
      done_d    = 1'b0;
      unique case (state_q)
         W_IDLE: begin
            if (i_wr_req) begin
               awaddr_d  = i_wr_addr;
               awprot_d  = i_wr_prot;
               wdata_d   = i_wr_data;
               wstrb_d   = i_wr_strb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end
         end
         W_SEND: begin
            if (awvalid_q && axi.awready) awvalid_d = 1'b0;
            if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
            if (aw_fin && w_fin)          bready_d  = 1'b1;
         end
         W_RESP: begin
            if (axi.bvalid && bready_q) begin
               resp_d   = axi.bresp;
               bready_d = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign axi.awaddr  = awaddr_q;
   assign axi.awprot  = awprot_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign o_wr_busy   = (state_q != W_IDLE);
   assign o_wr_done   = done_q;
   assign o_wr_resp   = resp_q;

endmodule

// File: rtl/axi_lite_master_interface.sv
// AXI-Lite master: independent write (sub-module) and read engines.
// Ports: clk_i/resetn_i, i_wr_*/o_wr_*, i_rd_*/o_rd_*, axi (master).
module axi_lite_master_interface
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH      = DATA_W_DEF,
   parameter int unsigned TRANS_W_STRB_W  = STRB_W_DEF,
   parameter int unsigned TRANS_WR_RESP_W = RESP_W_DEF,
   parameter int unsigned TRANS_PROT      = PROT_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       resetn_i,
   input  logic                       i_wr_req,
   input  logic [ADDR_WIDTH-1:0]      i_wr_addr,
   input  logic [DATA_WIDTH-1:0]      i_wr_data,
   input  logic [TRANS_W_STRB_W-1:0]  i_wr_strb,
   input  logic [TRANS_PROT-1:0]      i_wr_prot,
   output logic                       o_wr_busy,
   output logic                       o_wr_done,
   output logic [TRANS_WR_RESP_W-1:0] o_wr_resp,
   input  logic                       i_rd_req,
   input  logic [ADDR_WIDTH-1:0]      i_rd_addr,
   input  logic [TRANS_PROT-1:0]      i_rd_prot,
   output logic                       o_rd_busy,
   output logic                       o_rd_done,
   output logic [DATA_WIDTH-1:0]      o_rd_data,
   output logic [TRANS_WR_RESP_W-1:0] o_rd_resp,
   axi_lite_master_interface_if.master axi
);

   axi_lite_master_wr_engine #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .TRANS_W_STRB_W  (TRANS_W_STRB_W),
      .TRANS_WR_RESP_W (TRANS_WR_RESP_W),
      .TRANS_PROT      (TRANS_PROT)
   ) u_wr (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .i_wr_req  (i_wr_req),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_wr_strb (i_wr_strb),
      .i_wr_prot (i_wr_prot),
      .o_wr_busy (o_wr_busy),
      .o_wr_done (o_wr_done),
      .o_wr_resp (o_wr_resp),
      .axi       (axi)
   );

   rd_state_e                  rstate_q, rstate_d;
   logic [ADDR_WIDTH-1:0]      araddr_q, araddr_d;
   logic [TRANS_PROT-1:0]      arprot_q, arprot_d;
   logic                       arvalid_q, arvalid_d;
   logic                       rready_q, rready_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [TRANS_WR_RESP_W-1:0] rresp_q, rresp_d;
   logic                       rdone_q, rdone_d;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rstate_q  <= R_IDLE;
         araddr_q  <= '0;
         arprot_q  <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rdone_q   <= 1'b0;
      end else begin
         rstate_q  <= rstate_d;
         araddr_q  <= araddr_d;
         arprot_q  <= arprot_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rdone_q   <= rdone_d;
      end
   end

   always_comb begin
      rstate_d = rstate_q;
      unique case (rstate_q)
         R_IDLE: if (i_rd_req) rstate_d = R_ADDR;
         R_ADDR: if (arvalid_q && axi.arready) rstate_d = R_DATA;
         R_DATA: if (axi.rvalid && rready_q) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      araddr_d  = araddr_q;
      arprot_d  = arprot_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rdone_d   = 1'b0;
      unique case (rstate_q)
         R_IDLE: begin
            if (i_rd_req) begin
               araddr_d  = i_rd_addr;
               arprot_d  = i_rd_prot;
               arvalid_d = 1'b1;
            end
         end
         R_ADDR: begin
            if (arvalid_q && axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         R_DATA: begin
            if (axi.rvalid && rready_q) begin
               rdata_d  = axi.rdata;
               rresp_d  = axi.rresp;
               rready_d = 1'b0;
               rdone_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign axi.araddr  = araddr_q;
   assign axi.arprot  = arprot_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign o_rd_busy   = (rstate_q != R_IDLE);
   assign o_rd_done   = rdone_q;
   assign o_rd_data   = rdata_q;
   assign o_rd_resp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// Directed bench for axi_lite_master_interface: the bench plays the
// AXI-Lite slave and checks the master against hand-computed values.
module tb_axi_lite_master_interface;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        i_wr_req;
   logic [31:0] i_wr_addr;
   logic [31:0] i_wr_data;
   logic [3:0]  i_wr_strb;
   logic [2:0]  i_wr_prot;
   logic        o_wr_busy;
   logic        o_wr_done;
   logic [1:0]  o_wr_resp;
   logic        i_rd_req;
   logic [31:0] i_rd_addr;
   logic [2:0]  i_rd_prot;
   logic        o_rd_busy;
   logic        o_rd_done;
   logic [31:0] o_rd_data;
   logic [1:0]  o_rd_resp;

   axi_lite_master_interface_if axi ();

   axi_lite_master_interface dut (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .i_wr_req  (i_wr_req),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_wr_strb (i_wr_strb),
      .i_wr_prot (i_wr_prot),
      .o_wr_busy (o_wr_busy),
      .o_wr_done (o_wr_done),
      .o_wr_resp (o_wr_resp),
      .i_rd_req  (i_rd_req),
      .i_rd_addr (i_rd_addr),
      .i_rd_prot (i_rd_prot),
      .o_rd_busy (o_rd_busy),
      .o_rd_done (o_rd_done),
      .o_rd_data (o_rd_data),
      .o_rd_resp (o_rd_resp),
      .axi       (axi)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      resetn_i    = 1'b0;
      i_wr_req    = 1'b0;
      i_wr_addr   = '0;
      i_wr_data   = '0;
      i_wr_strb   = '0;
      i_wr_prot   = '0;
      i_rd_req    = 1'b0;
      i_rd_addr   = '0;
      i_rd_prot   = '0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bresp   = 2'b00;
      axi.bvalid  = 1'b0;
      axi.arready = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      axi.rvalid  = 1'b0;
      tick();
      tick();
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid", axi.wvalid, 0);
      chk("rst_bready", axi.bready, 0);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_rready", axi.rready, 0);
      chk("rst_wr_busy", o_wr_busy, 0);
      chk("rst_rd_busy", o_rd_busy, 0);
      chk("rst_awaddr", axi.awaddr, 0);
      chk("rst_rd_data", o_rd_data, 0);
      resetn_i = 1'b1;
      tick();

      // Write, slave ready at once
      i_wr_req    = 1'b1;
      i_wr_addr   = 32'h0000_0010;
      i_wr_data   = 32'hDEAD_BEEF;
      i_wr_strb   = 4'hF;
      i_wr_prot   = 3'd0;
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      tick();
      i_wr_req = 1'b0;
      chk("w1_awvalid", axi.awvalid, 1);
      chk("w1_wvalid", axi.wvalid, 1);
      chk("w1_awaddr", axi.awaddr, 32'h10);
      chk("w1_wdata", axi.wdata, 32'hDEAD_BEEF);
      chk("w1_wstrb", axi.wstrb, 4'hF);
      chk("w1_busy", o_wr_busy, 1);
      tick();
      chk("w1_awvalid_clr", axi.awvalid, 0);
      chk("w1_wvalid_clr", axi.wvalid, 0);
      chk("w1_bready", axi.bready, 1);
      chk("w1_done_early", o_wr_done, 0);
      axi.bvalid = 1'b1;
      axi.bresp  = 2'b00;
      tick();
      axi.bvalid = 1'b0;
      chk("w1_done", o_wr_done, 1);
      chk("w1_resp", o_wr_resp, 2'b00);
      chk("w1_bready_clr", axi.bready, 0);
      chk("w1_busy_clr", o_wr_busy, 0);
      tick();
      chk("w1_done_pulse", o_wr_done, 0);

      // Write, W lags AW by three cycles, early bvalid, SLVERR
      i_wr_req    = 1'b1;
      i_wr_addr   = 32'h0000_0020;
      i_wr_data   = 32'hCAFE_F00D;
      i_wr_strb   = 4'h3;
      i_wr_prot   = 3'd1;
      axi.awready = 1'b1;
      axi.wready  = 1'b0;
      tick();
      i_wr_req = 1'b0;
      chk("w2_awvalid", axi.awvalid, 1);
      chk("w2_awprot", axi.awprot, 3'd1);
      tick();
      chk("w2_awvalid_clr", axi.awvalid, 0);
      chk("w2_wvalid_hold", axi.wvalid, 1);
      chk("w2_wdata", axi.wdata, 32'hCAFE_F00D);
      chk("w2_wstrb", axi.wstrb, 4'h3);
      axi.awready = 1'b0;
      axi.bvalid  = 1'b1;
      axi.bresp   = 2'b10;
      tick();
      chk("w2_wvalid_c3", axi.wvalid, 1);
      chk("w2_bready_c3", axi.bready, 0);
      chk("w2_done_c3", o_wr_done, 0);
      tick();
      chk("w2_wvalid_c4", axi.wvalid, 1);
      chk("w2_wdata_c4", axi.wdata, 32'hCAFE_F00D);
      chk("w2_done_c4", o_wr_done, 0);
      axi.wready = 1'b1;
      tick();
      chk("w2_wvalid_clr", axi.wvalid, 0);
      chk("w2_bready", axi.bready, 1);
      chk("w2_done_c5", o_wr_done, 0);
      tick();
      axi.bvalid = 1'b0;
      axi.wready = 1'b0;
      chk("w2_done", o_wr_done, 1);
      chk("w2_resp", o_wr_resp, 2'b10);
      tick();
      chk("w2_done_pulse", o_wr_done, 0);
      chk("w2_resp_hold", o_wr_resp, 2'b10);

      // Read, arready and rvalid each delayed two cycles
      i_rd_req    = 1'b1;
      i_rd_addr   = 32'h0000_0040;
      i_rd_prot   = 3'd2;
      axi.arready = 1'b0;
      tick();
      i_rd_req = 1'b0;
      chk("r1_arvalid", axi.arvalid, 1);
      chk("r1_araddr", axi.araddr, 32'h40);
      chk("r1_arprot", axi.arprot, 3'd2);
      chk("r1_busy", o_rd_busy, 1);
      tick();
      chk("r1_arvalid_c2", axi.arvalid, 1);
      chk("r1_rready_c2", axi.rready, 0);
      tick();
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      chk("r1_arvalid_clr", axi.arvalid, 0);
      chk("r1_rready", axi.rready, 1);
      tick();
      chk("r1_rready_c5", axi.rready, 1);
      chk("r1_done_c5", o_rd_done, 0);
      tick();
      axi.rvalid = 1'b1;
      axi.rdata  = 32'h1234_5678;
      axi.rresp  = 2'b00;
      tick();
      axi.rvalid = 1'b0;
      chk("r1_done", o_rd_done, 1);
      chk("r1_data", o_rd_data, 32'h1234_5678);
      chk("r1_resp", o_rd_resp, 2'b00);
      chk("r1_rready_clr", axi.rready, 0);
      tick();
      chk("r1_done_pulse", o_rd_done, 0);

      // Simultaneous write and read
      i_wr_req    = 1'b1;
      i_wr_addr   = 32'h0000_0100;
      i_wr_data   = 32'hA5A5_A5A5;
      i_wr_strb   = 4'hC;
      i_rd_req    = 1'b1;
      i_rd_addr   = 32'h0000_0200;
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      axi.arready = 1'b1;
      tick();
      i_wr_req = 1'b0;
      i_rd_req = 1'b0;
      chk("s_wr_busy", o_wr_busy, 1);
      chk("s_rd_busy", o_rd_busy, 1);
      chk("s_awaddr", axi.awaddr, 32'h100);
      chk("s_araddr", axi.araddr, 32'h200);
      tick();
      chk("s_bready", axi.bready, 1);
      chk("s_rready", axi.rready, 1);
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.arready = 1'b0;
      axi.bvalid  = 1'b1;
      axi.bresp   = 2'b00;
      axi.rvalid  = 1'b1;
      axi.rdata   = 32'h5A5A_5A5A;
      axi.rresp   = 2'b11;
      tick();
      axi.bvalid = 1'b0;
      axi.rvalid = 1'b0;
      chk("s_wr_done", o_wr_done, 1);
      chk("s_rd_done", o_rd_done, 1);
      chk("s_wr_resp", o_wr_resp, 2'b00);
      chk("s_rd_data", o_rd_data, 32'h5A5A_5A5A);
      chk("s_rd_resp", o_rd_resp, 2'b11);
      tick();

      // Request while busy is dropped
      i_wr_req    = 1'b1;
      i_wr_addr   = 32'h0000_0300;
      i_wr_data   = 32'h0BAD_F00D;
      i_wr_strb   = 4'hF;
      tick();
      chk("ig_awaddr_c1", axi.awaddr, 32'h300);
      i_wr_addr = 32'h0000_0999;
      i_wr_data = 32'hFFFF_FFFF;
      tick();
      chk("ig_awaddr_c2", axi.awaddr, 32'h300);
      chk("ig_wdata_c2", axi.wdata, 32'h0BAD_F00D);
      i_wr_req    = 1'b0;
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      tick();
      chk("ig_bready", axi.bready, 1);
      chk("ig_awaddr_c3", axi.awaddr, 32'h300);
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b1;
      axi.bresp   = 2'b01;
      tick();
      axi.bvalid = 1'b0;
      chk("ig_done", o_wr_done, 1);
      chk("ig_resp", o_wr_resp, 2'b01);
      tick();
      chk("ig_not_queued", o_wr_busy, 0);
      chk("ig_awvalid", axi.awvalid, 0);

      // Reset while AW/W outstanding
      i_wr_req  = 1'b1;
      i_wr_addr = 32'h0000_0400;
      i_wr_data = 32'h1111_2222;
      tick();
      i_wr_req = 1'b0;
      chk("rs_awvalid_pre", axi.awvalid, 1);
      #2;
      resetn_i = 1'b0;
      #1;
      chk("rs_awvalid", axi.awvalid, 0);
      chk("rs_wvalid", axi.wvalid, 0);
      chk("rs_busy", o_wr_busy, 0);
      chk("rs_awaddr", axi.awaddr, 0);
      chk("rs_wdata", axi.wdata, 0);
      chk("rs_wr_resp", o_wr_resp, 0);
      chk("rs_rd_data", o_rd_data, 0);
      chk("rs_rd_resp", o_rd_resp, 0);
      tick();
      chk("rs_done", o_wr_done, 0);
      tick();
      resetn_i = 1'b1;
      tick();
      chk("rs_idle_done", o_wr_done, 0);
      i_wr_req    = 1'b1;
      i_wr_addr   = 32'h0000_0500;
      i_wr_data   = 32'h3333_4444;
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      tick();
      i_wr_req = 1'b0;
      chk("rs2_awaddr", axi.awaddr, 32'h500);
      chk("rs2_wdata", axi.wdata, 32'h3333_4444);
      tick();
      chk("rs2_bready", axi.bready, 1);
      axi.bvalid = 1'b1;
      axi.bresp  = 2'b00;
      tick();
      axi.bvalid = 1'b0;
      chk("rs2_done", o_wr_done, 1);
      chk("rs2_resp", o_wr_resp, 2'b00);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
